// File: rtl/cve2_obi_mem_responder.sv
// -----------------------------------------------------------------------------
// cve2_obi_mem_responder
//
// Memory-side responder for one req/gnt/rvalid port of the core. It backs the
// port with a word-organised register-array memory and returns in-order
// responses a fixed number of cycles after the grant. The number of granted
// but unanswered transactions is bounded. Accesses outside the mapped window
// complete with a bus error.
//
// Parameters:
//   MemWords       number of 32-bit words (power of two, 16..65536)
//   BaseAddr       byte address of word 0 (aligned to MemWords*4)
//   Latency        cycles from the grant cycle to the rvalid cycle (1..4)
//   MaxOutstanding maximum granted-but-unanswered transactions (1..4)
//
// Ports:
//   clk_i     in   1   clock, rising edge
//   rst_ni    in   1   asynchronous active-low reset
//   req_i     in   1   request valid
//   gnt_o     out  1   request accepted this cycle (combinational)
//   addr_i    in  32   byte address, bits [1:0] ignored
//   we_i      in   1   1 = write, 0 = read
//   be_i      in   4   write byte enables
//   wdata_i   in  32   write data
//   rvalid_o  out  1   response valid, one cycle per transaction
//   rdata_o   out 32   read data, 0 for writes and errors
//   err_o     out  1   bus error, qualified by rvalid_o
//
// Optional feature (macro CVE2_MEM_RESP_STALL_EN):
//   An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) advances every
//   cycle and its bit 0 additionally gates gnt_o, producing deterministic
//   pseudo-random grant stalls. When the macro is undefined there is no LFSR.
// -----------------------------------------------------------------------------
module cve2_obi_mem_responder #(
   parameter int unsigned MemWords       = 1024,
   parameter logic [31:0] BaseAddr       = 32'h0000_0000,
   parameter int unsigned Latency        = 1,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int unsigned AddrW = $clog2(MemWords);
   localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] rdata;
   } resp_t;

   logic [31:0]      mem_q [MemWords];
   resp_t            pipe_q [Latency];
   resp_t            stage0_d;
   logic [CntW-1:0]  outstanding_q;
   logic [AddrW-1:0] word_idx;
   logic             in_range;
   logic             slot_free;
   logic             accept;

   // Byte offset within a word carries no information for a word memory.
   logic unused_addr;
   assign unused_addr = ^addr_i[1:0];

   // BaseAddr is aligned to the window size, so the window test reduces to
   // comparing the bits above the word index and the index is a plain slice.
   assign in_range = (addr_i[31:AddrW+2] == BaseAddr[31:AddrW+2]);
   assign word_idx = addr_i[AddrW+1:2];

   // A retiring response frees its slot in the same cycle, so a full counter
   // can still grant while rvalid_o is high.
   assign slot_free = (outstanding_q < MaxCnt) || rvalid_o;

`ifdef CVE2_MEM_RESP_STALL_EN
   logic [7:0] lfsr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lfsr_q <= 8'hA5;
      end else begin
         // Taps for x^8+x^6+x^5+x^4+1, shifting towards the MSB.
         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
   end

   assign gnt_o = req_i && slot_free && lfsr_q[0];
`else
   assign gnt_o = req_i && slot_free;
`endif

   assign accept = req_i && gnt_o;

   // NOTE: the storage array is deliberately left out of the reset: contents
   // survive a reset, and a reset fan-out to every word would stop FPGA tools
   // from mapping the array onto block/distributed RAM.
   always_ff @(posedge clk_i) begin
      if (accept && we_i && in_range) begin
         for (int i = 0; i < 4; i++) begin
            if (be_i[i]) begin
               mem_q[word_idx][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
      end
   end

   // Read data is captured from the array in the accept cycle, so a later
   // write to the same word cannot disturb a read that is already in flight.
   always_comb begin
      // NOTE: every field gets a default before any condition, so no path
      // leaves a value unassigned and no latch is inferred.
      stage0_d       = '0;
      stage0_d.valid = accept;
      if (accept) begin
         stage0_d.err = !in_range;
         if (in_range && !we_i) begin
            stage0_d.rdata = mem_q[word_idx];
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every stage reads
   // the value its neighbour held before the edge, giving a true shift.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(Latency); i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= stage0_d;
         for (int i = 1; i < int'(Latency); i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign rvalid_o = pipe_q[Latency-1].valid;
   assign err_o    = pipe_q[Latency-1].err;
   assign rdata_o  = pipe_q[Latency-1].rdata;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outstanding_q <= '0;
      end else if (accept && !rvalid_o) begin
         outstanding_q <= outstanding_q + CntW'(1);
      end else if (!accept && rvalid_o) begin
         outstanding_q <= outstanding_q - CntW'(1);
      end
   end

endmodule

// File: tb/tb_cve2_obi_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_cve2_obi_mem_responder
//
// Self-checking bench for cve2_obi_mem_responder (Latency=3, MaxOutstanding=2,
// MemWords=1024, BaseAddr=0). A behavioural model holds the memory as a plain
// array and the in-flight responses as a queue of {due cycle, err, data}; a
// compare process checks gnt_o and the response outputs every cycle. Directed
// sequences pin the model with literal expectations, then randomized traffic
// runs against it.
// -----------------------------------------------------------------------------
module tb_cve2_obi_mem_responder;

   localparam int unsigned MEM_WORDS = 1024;
   localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
   localparam int          LAT       = 3;
   localparam int          MAX_OUT   = 2;

   logic        clk_i   = 1'b0;
   logic        rst_ni  = 1'b1;
   logic        req_i   = 1'b0;
   logic        we_i    = 1'b0;
   logic [31:0] addr_i  = '0;
   logic [3:0]  be_i    = '0;
   logic [31:0] wdata_i = '0;
   logic        gnt_o;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;

   always #5 clk_i = ~clk_i;

   cve2_obi_mem_responder #(
      .MemWords       (MEM_WORDS),
      .BaseAddr       (BASE_ADDR),
      .Latency        (LAT),
      .MaxOutstanding (MAX_OUT)
   ) dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .req_i    (req_i),
      .gnt_o    (gnt_o),
      .addr_i   (addr_i),
      .we_i     (we_i),
      .be_i     (be_i),
      .wdata_i  (wdata_i),
      .rvalid_o (rvalid_o),
      .rdata_o  (rdata_o),
      .err_o    (err_o)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   // ---------------- behavioural model ----------------
   typedef struct {
      int          due;
      logic        err;
      logic [31:0] data;
      bit          known;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mdl_mem   [MEM_WORDS];
   bit   [3:0]  mdl_known [MEM_WORDS];

   logic [31:0] last_rdata  = '0;
   logic        last_err    = 1'b0;
   int          last_rv_cyc = 0;
   int          n_rvalid    = 0;

`ifdef CVE2_MEM_RESP_STALL_EN
   logic [7:0] lfsr_m = 8'hA5;
   initial forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) lfsr_m = 8'hA5;
      else         lfsr_m = {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
   end
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic bit addr_in_range(input logic [31:0] a);
      longint off;
      off = longint'({32'h0, a}) - longint'({32'h0, BASE_ADDR});
      return (off >= 0) && (off < longint'(MEM_WORDS) * 4);
   endfunction

   // Compare process: one pass per cycle, at the falling edge.
   initial begin : p_compare
      bit   due_now;
      bit   exp_gnt;
      exp_t e;
      int   idx;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            exp_q.delete();
            check("rst_gnt", {31'h0, gnt_o}, 32'h0);
            check("rst_rvalid", {31'h0, rvalid_o}, 32'h0);
            check("rst_rdata", rdata_o, 32'h0);
            check("rst_err", {31'h0, err_o}, 32'h0);
         end else begin
            due_now = (exp_q.size() != 0) && (exp_q[0].due == cyc);
            exp_gnt = req_i && ((exp_q.size() < MAX_OUT) || due_now);
`ifdef CVE2_MEM_RESP_STALL_EN
            exp_gnt = exp_gnt && lfsr_m[0];
`endif
            check("gnt", {31'h0, gnt_o}, {31'h0, exp_gnt});
            check("rvalid", {31'h0, rvalid_o}, {31'h0, due_now});
            if (due_now) begin
               e = exp_q.pop_front();
               check("err", {31'h0, err_o}, {31'h0, e.err});
               if (e.known) check("rdata", rdata_o, e.data);
            end
            if (rvalid_o === 1'b1) begin
               last_rdata  = rdata_o;
               last_err    = err_o;
               last_rv_cyc = cyc;
               n_rvalid++;
            end
            if (req_i && exp_gnt) begin
               e.due   = cyc + LAT;
               e.err   = 1'b0;
               e.data  = '0;
               e.known = 1'b1;
               if (!addr_in_range(addr_i)) begin
                  e.err = 1'b1;
               end else begin
                  idx = int'((addr_i - BASE_ADDR) >> 2);
                  if (we_i) begin
                     for (int b = 0; b < 4; b++) begin
                        if (be_i[b]) begin
                           mdl_mem[idx][8*b +: 8] = wdata_i[8*b +: 8];
                           mdl_known[idx][b]      = 1'b1;
                        end
                     end
                  end else begin
                     e.data  = mdl_mem[idx];
                     e.known = (mdl_known[idx] == 4'hF);
                  end
               end
               exp_q.push_back(e);
            end
         end
      end
   end

   // ---------------- driver ----------------
   // Raises req_i with the given payload and holds it until granted; returns
   // the grant cycle and the number of stalled cycles.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output int g_cyc, output int waits);
      bit got = 1'b0;
      req_i   = 1'b1;
      we_i    = we;
      addr_i  = addr;
      be_i    = be;
      wdata_i = wd;
      waits   = 0;
      g_cyc   = -1;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk_i);
         if (gnt_o === 1'b1) begin
            got   = 1'b1;
            g_cyc = cyc;
            break;
         end
         waits++;
      end
      if (!got) begin
         n_checks++;
         $display("FAIL grant_timeout: gnt_o stayed low for 64 cycles, expected a grant (addr %h)", addr);
      end
      @(posedge clk_i);
      #1;
      // Scramble the payload once req_i drops; it must be ignored.
      req_i   = 1'b0;
      we_i    = 1'($urandom);
      addr_i  = $urandom;
      be_i    = 4'($urandom);
      wdata_i = $urandom;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 100; k++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk_i);
         #1;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain_timeout: %0d responses still pending, expected 0", exp_q.size());
      end
      idle(1);
   endtask

   // ---------------- stimulus ----------------
   initial begin : p_main
      int g;
      int w;
      int g_burst[6];
      int exp_gap[6];
      int snap;
      int r;
      logic [31:0] a;

      exp_gap = '{0, 1, 3, 4, 6, 7};

      #2 rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;

      // Full-word write then read back.
      issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, g, w);
`ifndef CVE2_MEM_RESP_STALL_EN
      check("first_gnt_wait", w, 0);
`endif
      drain();
      check("wr_resp_rdata", last_rdata, 32'h0);
      check("wr_resp_err", {31'h0, last_err}, 32'h0);
      issue(1'b0, 32'h10, 4'h0, 32'h0, g, w);
      drain();
      check("rd_deadbeef", last_rdata, 32'hDEADBEEF);
      check("rd_latency", last_rv_cyc - g, LAT);

      // Byte-lane write over the previous value.
      issue(1'b1, 32'h10, 4'b0101, 32'h11223344, g, w);
      issue(1'b0, 32'h10, 4'h0, 32'h0, g, w);
      drain();
      check("rd_byte_en", last_rdata, 32'hDE22BE44);

      // Top word of the window, then one word past it.
      issue(1'b1, 32'h0FFC, 4'hF, 32'hCAFEF00D, g, w);
      issue(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, g, w);
      drain();
      check("oor_err", {31'h0, last_err}, 32'h1);
      check("oor_rdata", last_rdata, 32'h0);
      issue(1'b0, 32'h0FFC, 4'h0, 32'h0, g, w);
      drain();
      check("top_word", last_rdata, 32'hCAFEF00D);
      check("top_word_err", {31'h0, last_err}, 32'h0);

      // req_i held high for six reads: two slots, three-cycle latency.
      for (int i = 0; i < 6; i++) begin
         issue(1'b0, 32'h10, 4'h0, 32'h0, g_burst[i], w);
      end
      drain();
`ifndef CVE2_MEM_RESP_STALL_EN
      for (int i = 0; i < 6; i++) begin
         check($sformatf("burst_gnt_cycle%0d", i), g_burst[i] - g_burst[0], exp_gap[i]);
      end
`endif

      // Reset with two reads in flight.
      issue(1'b0, 32'h0FFC, 4'h0, 32'h0, g, w);
      issue(1'b0, 32'h10, 4'h0, 32'h0, g, w);
      rst_ni = 1'b0;
      snap   = n_rvalid;
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      issue(1'b0, 32'h10, 4'h0, 32'h0, g, w);
      check("post_rst_gnt_wait", w, 0);
      drain();
      check("post_rst_rvalid_count", n_rvalid, snap + 1);
      check("post_rst_rdata", last_rdata, 32'hDE22BE44);

      // Fill the low words so random reads have defined data.
      for (int i = 0; i < 64; i++) begin
         issue(1'b1, 32'(i * 4), 4'hF, $urandom, g, w);
      end

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         if (r < 7)      a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
         else if (r < 9) a = 32'h0FF0 + 32'($urandom_range(0, 31));
         else            a = $urandom;
         issue(1'($urandom), a, 4'($urandom), $urandom, g, w);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cve2_obi_mem_responder.md
Name: cve2_obi_mem_responder

Overview:
- Memory-side responder for the core's req/gnt/rvalid instruction and data interfaces.
- Backs one port with a word-organised register-array memory and returns in-order responses at a fixed latency.
- Used as the simulation and FPGA memory model behind the core top level; one instance per interface.
- Provides a bounded number of outstanding transactions and flags out-of-range accesses as bus errors.

Parameters:
- MemWords, 1024: number of 32-bit words stored. Power of two, 16..65536.
- BaseAddr, 32'h0000_0000: byte address of word 0. Must be aligned to MemWords*4.
- Latency, 1: cycles from the grant cycle to the rvalid cycle. Legal range 1..4.
- MaxOutstanding, 2: maximum granted-but-unanswered transactions. Legal range 1..4.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  request valid.
- gnt_o  out  1  request accepted this cycle.
- addr_i  in  32  byte address; bits [1:0] ignored.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  4  byte enables for writes; ignored for reads.
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid, one cycle per transaction.
- rdata_o  out  32  read data; 0 for writes and errors.
- err_o  out  1  bus error; qualified by rvalid_o.

Behaviour:
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0. Outstanding count=0, response pipeline empty.
- Memory array is not reset. Reading a never-written word returns undefined data (X in simulation).
- Acceptance: the transaction is accepted in the cycle where req_i && gnt_o.
- gnt_o = req_i && (outstanding_q < MaxOutstanding || rvalid_o). gnt_o is combinational and never asserted without req_i.
- Address decode: in range iff BaseAddr <= addr_i < BaseAddr + MemWords*4. Word index = (addr_i - BaseAddr) >> 2.
- In-range write: each byte lane i with be_i[i]=1 updates on the accept edge. Lanes with be_i[i]=0 keep their value. be_i=0 is a legal no-op write that still gets a response.
- In-range read: data is sampled from the array in the accept cycle.
  - A read accepted one cycle after a write to the same word returns the new data.
  - A write accepted after a read, while that read is still in flight, does not change the read's returned data.
- Out-of-range access: no array update; the response carries err_o=1 and rdata_o=0.
- Response pipeline: a shift register of depth Latency. Each stage holds {valid, err, rdata}.
  - Stage 0 is loaded on accept; the last stage drives the outputs.
  - rvalid_o rises exactly Latency cycles after the accept edge.
  - Responses are strictly in acceptance order; there is no backpressure on the response side.
- Outstanding counter: width clog2(MaxOutstanding+1).
  - +1 on accept, -1 when rvalid_o=1, unchanged when both happen in the same cycle.
  - Never exceeds MaxOutstanding; never underflows.
- Throughput: with MaxOutstanding >= Latency, one transaction per cycle. Otherwise grants stall until a response retires.
- req_i deasserted: no state change except the pipeline advancing.
- The address/write payload need not be held stable after grant.
- Reset mid-operation: in-flight responses are discarded (rvalid_o stays 0) and the counter clears. Memory contents are retained. The first cycle after reset release may grant.

Optional Feature:
- Macro: CVE2_MEM_RESP_STALL_EN.
- Defined:
  - Adds an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, reset to 8'hA5, advancing every cycle.
  - gnt_o is additionally ANDed with lfsr_q[0], giving deterministic pseudo-random grant stalls to exercise core wait states.
- Undefined: no LFSR logic; gnt_o follows the base rule only.

Test Plan:
- Defaults: write 32'hDEADBEEF to 0x10 with be=4'hF, then read 0x10.
  - Both requests are granted in their request cycle.
  - The read's rvalid_o comes 1 cycle after its grant with rdata_o=32'hDEADBEEF, err_o=0.
  - The write response has rdata_o=0.
- Byte enables: write 32'h11223344 with be=4'b0101 over 32'hDEADBEEF at 0x10, then read 0x10 -> rdata_o=32'hDE22BE44.
- Out of range (MemWords=1024): write 32'hFFFFFFFF to 0x1000, then read 0x0FFC.
  - The write response has err_o=1, rdata_o=0.
  - The read of 0x0FFC has err_o=0 and returns the value held before the write.
- Latency=2, MaxOutstanding=1, req_i held high with 4 reads:
  - Grants occur on cycles 0, 2, 4, 6.
  - rvalid_o occurs on cycles 2, 4, 6, 8.
  - With MaxOutstanding=2, grants occur on cycles 0-3 and rvalid_o on cycles 2-5.
- Reset mid-flight: Latency=3, two reads granted, then rst_ni pulled low for 1 cycle.
  - rvalid_o never asserts for those reads.
  - After release, a new read is granted immediately and returns the previously written data.
- With CVE2_MEM_RESP_STALL_EN, req_i held high from reset release:
  - The gnt_o pattern over 16 cycles matches lfsr_q[0] of the 8'hA5-seeded sequence (cycle 0 grants, since 8'hA5[0]=1).
  - Read data ordering and values are unchanged.
